// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and state encoding for the SRAM port-0 read/write controller.
package sram_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int NUM_WMASKS_DEF = 4;
  localparam logic [31:0] INIT_VALUE_DEF = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through response FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           valid,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign valid    = (count != '0);
  assign do_pop   = pop & valid;
  assign do_push  = push & ((count != CW'(DEPTH)) | do_pop);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  // Storage is not reset: entries are only visible once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Port-0 front end for the 32x256 RW/R SRAM macro. Define
// SRAM_RW_PORT_CTRL_INIT_EN to sweep the array to INIT_VALUE after reset.
module sram_rw_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    NUM_WMASKS = NUM_WMASKS_DEF,
  parameter int                    RSP_DEPTH  = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(INIT_VALUE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_inflight;
  logic                  pop;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ;
  logic                  rd_room;

`ifdef SRAM_RW_PORT_CTRL_INIT_EN
  state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + ADDR_WIDTH'(1);
      end else begin
        init_cnt <= init_cnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (init_cnt == '1) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_INIT;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end
`else
  assign state    = ST_RUN;
  assign init_cnt = '0;
`endif

  assign init_done = (state == ST_RUN);
  assign pop       = rsp_valid & rsp_ready;

  // Slots already promised: stored entries plus the read whose data lands next edge.
  assign occ     = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight} - {{CW{1'b0}}, pop};
  assign rd_room = (occ < (CW + 1)'(RSP_DEPTH));

  always_comb begin
    req_ready   = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (rst) begin
      req_ready = 1'b0;
      sram_csb0 = 1'b1;
      sram_web0 = 1'b1;
    end else if (state == ST_INIT) begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_wmask0 = '1;
      sram_addr0  = init_cnt;
      sram_din0   = INIT_VALUE;
    end else begin
      req_ready   = req_we ? 1'b1 : rd_room;
      sram_csb0   = !(req_valid & req_ready);
      sram_web0   = !req_we;
      sram_wmask0 = req_wmask;
      sram_addr0  = req_addr;
      sram_din0   = req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= req_valid & req_ready & ~req_we;
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (sram_dout0),
    .pop       (pop),
    .pop_data  (rsp_data),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed bench for sram_rw_port_ctrl with a behavioural macro model and a
// response scoreboard; adapts expectations to SRAM_RW_PORT_CTRL_INIT_EN.
module tb_sram_rw_port_ctrl;

`ifdef SRAM_RW_PORT_CTRL_INIT_EN
  localparam logic [31:0] FRESH     = 32'h0000_0000;
  localparam int          INIT_CYC  = 256;
  localparam logic [31:0] AFTER_30  = 32'h0000_0000;
  localparam logic [31:0] AFTER_10  = 32'h0000_0000;
  localparam logic [31:0] RST_IDONE = 32'h0;
`else
  localparam logic [31:0] FRESH     = 32'hA5A5_A5A5;
  localparam int          INIT_CYC  = 0;
  localparam logic [31:0] AFTER_30  = 32'h1234_5678;
  localparam logic [31:0] AFTER_10  = 32'hDEAD_BEEF;
  localparam logic [31:0] RST_IDONE = 32'h1;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        init_done;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  sram_rw_port_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_wmask   (req_wmask),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .init_done   (init_done),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: controls captured at posedge, array accessed at negedge.
  logic [31:0] mem [256];
  logic        cap_csb;
  logic        cap_web;
  logic [3:0]  cap_wm;
  logic [7:0]  cap_a;
  logic [31:0] cap_d;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_A5A5;

  always @(posedge clk) begin
    cap_csb <= sram_csb0;
    cap_web <= sram_web0;
    cap_wm  <= sram_wmask0;
    cap_a   <= sram_addr0;
    cap_d   <= sram_din0;
  end

  always @(negedge clk) begin
    if (cap_csb === 1'b0) begin
      if (cap_web === 1'b0) begin
        for (int l = 0; l < 4; l++)
          if (cap_wm[l]) mem[cap_a][l*8 +: 8] <= cap_d[l*8 +: 8];
      end else begin
        sram_dout0 <= mem[cap_a];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc_g = 0;
  logic [31:0] exp_q [$];
  int          pop_cyc [$];

  always @(posedge clk) cyc_g <= cyc_g + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] ex);
    n_vec++;
    if (got !== ex) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, ex);
    end
  endfunction

  function automatic void fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", name);
  endfunction

  // Scoreboard monitor: pops on every response handshake, checks held data while stalled.
  initial begin
    logic        held;
    logic [31:0] held_data;
    held = 1'b0;
    held_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rsp_valid && held) chk("rsp_hold", rsp_data, held_data);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_data, 32'hxxxx_xxxx);
        end else begin
          chk("rsp_data", rsp_data, exp_q.pop_front());
        end
        pop_cyc.push_back(cyc_g);
        held = 1'b0;
      end else if (rsp_valid) begin
        held = 1'b1;
        held_data = rsp_data;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [3:0] wm, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] ex, output int stalls);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_wmask = wm;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    stalls = n;
    if (!req_ready) begin
      fail("req_handshake");
    end else begin
      @(posedge clk);
      if (!we) exp_q.push_back(ex);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int cyc, nwr, bad;
    cyc = 0;
    nwr = 0;
    bad = 0;
    forever begin
      @(negedge clk);
      if (init_done || cyc >= 1000) break;
      if (!sram_csb0 && !sram_web0) begin
        if (sram_addr0 !== nwr[7:0] || sram_din0 !== 32'h0 || sram_wmask0 !== 4'hF) bad++;
        nwr++;
      end
      @(posedge clk);
      cyc++;
    end
    chk("init_done", 32'(init_done), 32'h1);
    chk("init_cycles", cyc, INIT_CYC);
    chk("init_writes", nwr, INIT_CYC);
    chk("init_addr_seq", bad, 32'h0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_init_done"}, 32'(init_done), RST_IDONE);
    chk({tag, "_csb0"}, 32'(sram_csb0), 32'h1);
    chk({tag, "_web0"}, 32'(sram_web0), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    int gap_bad;
    logic [31:0] b2b_exp [8];

    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_wmask = 4'hA;
    req_addr  = 8'h55;
    req_wdata = 32'hCAFE_F00D;
    rsp_ready = 1'b1;

    // Reset values, with a read request held to show it is gated.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("rst");
    chk("rst_wmask0", 32'(sram_wmask0), 32'h0);
    chk("rst_addr0", 32'(sram_addr0), 32'h0);
    chk("rst_din0", sram_din0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    wait_init();

    do_req(1'b0, 4'h0, 8'h7F, 32'h0, FRESH, st);
    req_valid = 1'b0;
    drain();

    // Write then read next cycle; response one cycle after the read handshake.
    do_req(1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, 32'h0, st);
    do_req(1'b0, 4'h0, 8'h10, 32'h0, 32'hDEAD_BEEF, st);
    req_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle0_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(rsp_valid), 32'h1);
    drain();

    do_req(1'b1, 4'hF, 8'h20, 32'hFFFF_FFFF, 32'h0, st);
    do_req(1'b1, 4'h5, 8'h20, 32'h0000_0000, 32'h0, st);
    do_req(1'b0, 4'h0, 8'h20, 32'h0, 32'hFF00_FF00, st);
    req_valid = 1'b0;
    drain();

    // Backpressure: third read stalls until the consumer drains.
    do_req(1'b1, 4'hF, 8'h01, 32'h1111_1111, 32'h0, st);
    do_req(1'b1, 4'hF, 8'h02, 32'h2222_2222, 32'h0, st);
    do_req(1'b1, 4'hF, 8'h03, 32'h3333_3333, 32'h0, st);
    rsp_ready = 1'b0;
    do_req(1'b0, 4'h0, 8'h01, 32'h0, 32'h1111_1111, st);
    do_req(1'b0, 4'h0, 8'h02, 32'h0, 32'h2222_2222, st);
    req_we   = 1'b0;
    req_addr = 8'h03;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'h0);
      chk("stall_csb0", 32'(sram_csb0), 32'h1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    do_req(1'b0, 4'h0, 8'h03, 32'h0, 32'h3333_3333, st);
    req_valid = 1'b0;
    drain();

    // Back-to-back reads at full rate.
    b2b_exp[0] = FRESH;
    b2b_exp[1] = 32'h1111_1111;
    b2b_exp[2] = 32'h2222_2222;
    b2b_exp[3] = 32'h3333_3333;
    b2b_exp[4] = FRESH;
    b2b_exp[5] = FRESH;
    b2b_exp[6] = FRESH;
    b2b_exp[7] = FRESH;
    pop_cyc.delete();
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 4'h0, 8'(i), 32'h0, b2b_exp[i], st);
      tot += st;
    end
    req_valid = 1'b0;
    drain();
    chk("b2b_stalls", tot, 32'h0);
    chk("b2b_rsp_count", pop_cyc.size(), 32'd8);
    gap_bad = 0;
    for (int i = 1; i < pop_cyc.size(); i++)
      if (pop_cyc[i] - pop_cyc[i-1] != 1) gap_bad++;
    chk("b2b_rsp_gaps", gap_bad, 32'h0);

    // Reset right after a read handshake discards that read.
    do_req(1'b1, 4'hF, 8'h30, 32'h1234_5678, 32'h0, st);
    do_req(1'b0, 4'h0, 8'h30, 32'h0, 32'h1234_5678, st);
    rst = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      reset_checks("rst2");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    wait_init();
    do_req(1'b0, 4'h0, 8'h30, 32'h0, AFTER_30, st);
    do_req(1'b0, 4'h0, 8'h10, 32'h0, AFTER_10, st);
    req_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
